// File: rtl/dmem_reader.sv
// Block reader: streams up to 16 consecutive data-memory words through a small output FIFO.
// Optional running checksum is enabled with the macro DMEM_READER_CHECKSUM_EN.
module dmem_reader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [4:0]        num_words,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_en_q;
    logic              rvld_q;
    logic              busy_q;
    logic              done_q;
    logic [4:0]        nwords_q;
    logic [4:0]        issued_q;

    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [CNT_W-1:0]  count_q;

    logic [4:0]        n_clip;
    logic              accept;
    logic              issue;
    logic              push;
    logic              pop;
    logic              drain_empty;
    logic [CNT_W:0]    pending;

    assign n_clip  = (num_words > 5'd16) ? 5'd16 : num_words;
    assign accept  = (state_q == IDLE) && start;

    // Buffered words plus both reads still in the memory pipeline must leave room for one more.
    assign pending = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_en_q} + {{CNT_W{1'b0}}, rvld_q};
    assign issue   = (accept && (n_clip != 5'd0)) ||
                     ((state_q == FETCH) && (issued_q != nwords_q) &&
                      (pending < (CNT_W+1)'(FIFO_DEPTH)));

    assign push        = rvld_q;
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign out_data    = out_valid ? fifo_q[rptr_q] : '0;
    assign drain_empty = !rvld_q && ((count_q == '0) || ((count_q == CNT_W'(1)) && pop));

    assign mem_addr  = addr_q;
    assign mem_rd_en = rd_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            rvld_q   <= 1'b0;
            nwords_q <= '0;
            issued_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rd_en_q <= issue;
            rvld_q  <= rd_en_q;
            if (issue) begin
                addr_q   <= accept ? base_addr : addr_q + ADDR_W'(1);
                issued_q <= accept ? 5'd1 : issued_q + 5'd1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        nwords_q <= n_clip;
                        busy_q   <= 1'b1;
                        if (n_clip == 5'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issued_q == nwords_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= mem_rdata;
    end

`ifdef DMEM_READER_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q + 16'(out_data);
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dmem_reader.sv
// Bench for dmem_reader: job-level scoreboard checked every cycle, directed scenarios and random jobs.
module tb_dmem_reader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 4;
`ifdef DMEM_READER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [4:0]        num_words;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [15:0]       checksum;

    dmem_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Data memory with one cycle read latency
    logic [DATA_W-1:0] mem [4096];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Job-level model state
    bit  armed = 0;
    bit  m_busy = 0, m_done = 0;
    int  rem = 0, m_sum = 0, outstanding = 0;
    int  exp_addr[$];
    int  exp_data[$];
    bit  prev_hold = 0;
    int  prev_data = 0;
    int  cyc = 0;

    // Per-job log used by the directed scenarios
    int  job_start = 0, first_rd = -1, first_val = -1, last_xfer = -1, done_cyc = -1;
    int  busy_cnt = 0, rd_cnt = 0, max_out = 0;
    int  addr_log[$];
    int  data_log[$];
    bit  done_seen = 0;

    initial begin
        bit xfer;
        int got;
        int nn;
        int a;
        forever begin
            @(negedge clk);
            cyc++;
            xfer = 1'b0;
            got  = 0;
            if (armed) begin
                chk("busy", busy, m_busy);
                chk("done", done, m_done);
                if (!m_busy) chk("valid_idle", out_valid, 0);
                if (prev_hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, prev_data);
                end
                if (mem_rd_en) begin
                    rd_cnt++;
                    if (first_rd < 0) first_rd = cyc;
                    addr_log.push_back(int'(mem_addr));
                    outstanding++;
                    if (outstanding > max_out) max_out = outstanding;
                    chk("rd_expected", int'(exp_addr.size() > 0), 1);
                    if (exp_addr.size() > 0) chk("mem_addr", mem_addr, exp_addr.pop_front());
                    chk("outstanding_le_depth", int'(outstanding <= DEPTH), 1);
                end
                if (out_valid && first_val < 0) first_val = cyc;
                if (busy) busy_cnt++;
                xfer = out_valid && out_ready;
                if (xfer) begin
                    chk("xfer_expected", int'(exp_data.size() > 0), 1);
                    if (exp_data.size() > 0) begin
                        got = exp_data.pop_front();
                        chk("out_data", out_data, got);
                    end
                    data_log.push_back(int'(out_data));
                    last_xfer = cyc;
                    outstanding--;
                end
                chk("checksum", checksum, CSUM_ON ? (m_sum & 16'hFFFF) : 0);
                if (done) begin
                    done_seen = 1'b1;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (m_done) chk("done_all_served", exp_data.size() + exp_addr.size(), 0);
            end
            // Advance the model to the state expected after the coming edge
            if (rst) begin
                m_busy = 0; m_done = 0; rem = 0; m_sum = 0; outstanding = 0;
                exp_addr.delete(); exp_data.delete();
            end else if (m_done) begin
                m_busy = 0; m_done = 0;
            end else if (!m_busy && start) begin
                nn = (num_words > 5'd16) ? 16 : int'(num_words);
                rem = nn; m_sum = 0; m_busy = 1; m_done = (nn == 0);
                for (int i = 0; i < nn; i++) begin
                    a = (int'(base_addr) + i) % 4096;
                    exp_addr.push_back(a);
                    exp_data.push_back(int'(mem[a]));
                end
                job_start = cyc; first_rd = -1; first_val = -1; last_xfer = -1; done_cyc = -1;
                busy_cnt = 0; rd_cnt = 0; max_out = 0; outstanding = 0; done_seen = 0;
                addr_log.delete(); data_log.delete();
            end else if (m_busy && xfer) begin
                rem--;
                m_sum = (m_sum + got) & 16'hFFFF;
                if (rem == 0) m_done = 1;
            end
            prev_hold = !rst && out_valid && !out_ready;
            prev_data = int'(out_data);
            if (rst) armed = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int n);
        base_addr = ADDR_W'(b);
        num_words = 5'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int k;
        k = 0;
        while (!done_seen && k < budget) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        chk("job_finished", done_seen, 1);
        out_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int k;
        int nn;
        int exp_wrap[4];
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = DATA_W'(i + 1);
        step();
        step();
        rst = 1'b0;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        step();

        // Full 16-word block from address 0 with a free-running consumer
        do_start(0, 16);
        wait_done(100, 1'b0);
        chk("t1_first_rd_lat", first_rd - job_start, 1);
        chk("t1_first_valid_lat", first_val - job_start, 3);
        chk("t1_count", data_log.size(), 16);
        for (int i = 0; i < 16 && i < data_log.size(); i++) chk("t1_word", data_log[i], i + 1);
        chk("t1_back_to_back", last_xfer - first_val, 15);
        chk("t1_done_after_last", done_cyc - last_xfer, 1);
        chk("t1_checksum", checksum, CSUM_ON ? 136 : 0);

        // Address wrap at the top of memory
        exp_wrap = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        do_start(12'hFFE, 4);
        wait_done(100, 1'b0);
        chk("t2_rd_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t2_addr", addr_log[i], exp_wrap[i]);

        // Consumer stalls for 10 cycles from the first valid word
        do_start(12'h040, 8);
        k = 0;
        while (!out_valid && k < 20) begin step(); k++; end
        out_ready = 1'b0;
        chk("t3_saw_valid", out_valid, 1);
        repeat (10) step();
        out_ready = 1'b1;
        wait_done(100, 1'b0);
        chk("t3_count", data_log.size(), 8);
        for (int i = 0; i < 8 && i < data_log.size(); i++) chk("t3_word", data_log[i], 12'h041 + i);
        chk("t3_max_outstanding", int'(max_out <= DEPTH), 1);

        // Zero-length request
        do_start(12'h123, 0);
        wait_done(20, 1'b0);
        chk("t4_busy_cycles", busy_cnt, 1);
        chk("t4_reads", rd_cnt, 0);
        chk("t4_done_lat", done_cyc - job_start, 1);

        // Reset in the middle of a block, colliding with a start, then a short fresh block
        do_start(0, 16);
        k = 0;
        while (data_log.size() < 4 && k < 50) begin step(); k++; end
        chk("t5_reached_word5", data_log.size(), 4);
        rst = 1'b1; start = 1'b1; base_addr = 12'h200; num_words = 5'd3;
        step();
        rst = 1'b0; start = 1'b0;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_data", out_data, 0);
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_rd_en", mem_rd_en, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_checksum", checksum, 0);
        step();
        do_start(12'h100, 2);
        wait_done(50, 1'b0);
        chk("t5_count", data_log.size(), 2);
        if (data_log.size() == 2) begin
            chk("t5_word0", data_log[0], 12'h101);
            chk("t5_word1", data_log[1], 12'h102);
        end

        // Start pulsed while busy must not disturb the running block
        do_start(12'h010, 6);
        step();
        step();
        base_addr = 12'h500; num_words = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(100, 1'b0);
        chk("t6_rd_count", addr_log.size(), 6);
        for (int i = 0; i < 6 && i < addr_log.size(); i++) chk("t6_addr", addr_log[i], 12'h010 + i);
        chk("t6_count", data_log.size(), 6);

        // Random blocks with random back-pressure and stray starts
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < 4096; i++) mem[i] = DATA_W'($urandom);
            nn = $urandom_range(0, 20);
            do_start($urandom_range(0, 4095), nn);
            if ($urandom_range(0, 1) == 1) begin
                base_addr = ADDR_W'($urandom); num_words = 5'($urandom_range(1, 16)); start = 1'b1;
                step();
                start = 1'b0;
            end
            wait_done(400, 1'b1);
            chk("rand_count", data_log.size(), (nn > 16) ? 16 : nn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_reader.md
DMEM_READER -- requirements
Module: dmem_reader

Interface
- REQ-001 SHALL have parameter ADDR_W, default 12, data-memory address width.
- REQ-002 SHALL have parameter DATA_W, default 12, data-memory read-data width (memory-to-bus width).
- REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, power of two, at least 2.
- REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
- REQ-005 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
- REQ-006 SHALL have port start, input, 1 bit, request to begin a block read; sampled only in IDLE.
- REQ-007 SHALL have port base_addr, input, ADDR_W bits, first word address; captured with start.
- REQ-008 SHALL have port num_words, input, 5 bits, word count 0..16; captured with start.
- REQ-009 SHALL have port mem_addr, output, ADDR_W bits, read address to data memory.
- REQ-010 SHALL have port mem_rd_en, output, 1 bit, read strobe to data memory.
- REQ-011 SHALL have port mem_rdata, input, DATA_W bits, memory read data, valid exactly one cycle after mem_rd_en.
- REQ-012 SHALL have port out_data, output, DATA_W bits, streamed word.
- REQ-013 SHALL have port out_valid, output, 1 bit, out_data holds a word.
- REQ-014 SHALL have port out_ready, input, 1 bit, consumer accepts; transfer when out_valid and out_ready are both high.
- REQ-015 SHALL have port busy, output, 1 bit, high in every state except IDLE.
- REQ-016 SHALL have port done, output, 1 bit, single-cycle pulse after the last word transfers.
- REQ-017 SHALL have port checksum, output, 16 bits, running sum of transferred words (see Configuration).

Function
- REQ-018 SHALL implement states IDLE, FETCH, DRAIN, DONE.
- REQ-019 SHALL move IDLE->FETCH on start with num_words>0, and IDLE->DONE on start with num_words==0.
- REQ-020 SHALL clip num_words values above 16 to 16.
- REQ-021 SHALL, in FETCH, assert mem_rd_en only when (FIFO occupancy + reads in flight) < FIFO_DEPTH.
- REQ-022 SHALL issue addresses base_addr, base_addr+1, ... modulo 2^ADDR_W, wrapping from 0xFFF to 0x000.
- REQ-023 SHALL write mem_rdata into the FIFO on the cycle after each mem_rd_en; no read is ever dropped.
- REQ-024 SHALL move FETCH->DRAIN in the cycle after the last read is issued, DRAIN->DONE when the FIFO is empty and no read is in flight, and DONE->IDLE unconditionally after one cycle.
- REQ-025 SHALL assert done only in DONE.
- REQ-026 SHALL deliver words in address order with one cycle read latency: with start sampled at cycle T and out_ready held high, mem_rd_en is first high at T+1, out_valid at T+3, and throughput is 1 word per cycle.
- REQ-027 SHALL hold out_data stable while out_valid is high and out_ready is low.
- REQ-028 SHALL allow a FIFO push and pop in the same cycle when the FIFO is full, with occupancy unchanged.
- REQ-029 SHALL ignore start while busy.
- REQ-030 SHALL drive mem_rd_en low outside FETCH.

Reset
- REQ-031 SHALL, with rst high at a clock edge, enter IDLE, empty the FIFO, discard any in-flight read data, and drive mem_addr=0, mem_rd_en=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0.
- REQ-032 SHALL let reset asserted mid-operation override every other input, including start in the same cycle.

Configuration
- REQ-033 SHALL, with macro DMEM_READER_CHECKSUM_EN defined, clear checksum on accepted start and add each transferred word, zero-extended, modulo 2^16; checksum holds after done until the next start.
- REQ-034 SHALL, without DMEM_READER_CHECKSUM_EN, tie checksum to 0 and contain no accumulator logic.

Verification
- REQ-035 SHALL cover: memory[i]=i+1, base 0, num_words 16, out_ready high -> words 1..16 on consecutive cycles from T+3, done one cycle after the last transfer, checksum 136 (macro on) or 0 (macro off).
- REQ-036 SHALL cover: base 0xFFE, num_words 4 -> mem_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
- REQ-037 SHALL cover: out_ready low for 10 cycles after the first out_valid, num_words 8 -> at most FIFO_DEPTH reads outstanding, out_data stable throughout, all 8 words delivered in order.
- REQ-038 SHALL cover: start with num_words 0 -> busy high for one cycle, done pulse at T+1, mem_rd_en never high.
- REQ-039 SHALL cover: rst pulsed at the 5th word of a 16-word read, then a new start with base 0x100, num_words 2 -> the new read returns only those 2 words, with no stale data.
- REQ-040 SHALL cover: start pulsed while busy -> no change to the address sequence or word count.
